uart_report_sequencer: RTL and testbench



---
 rtl/uart_report_sequencer_pkg.sv | 35 +++
 rtl/uart_report_sequencer_if.sv | 18 +
 rtl/uart_report_sequencer_bin2bcd.sv | 64 ++++++
 rtl/uart_report_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_uart_report_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_report_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_report_pkg
// Shared definitions for the UART report sequencer:
//   - state_t : report FSM states
//   - ASCII byte constants used when formatting a report line
//   - pow10() : constant helper used to build the saturation limit
// Optional build macro affecting users of this package: REPORT_ZERO_SUPPRESS_EN
// -----------------------------------------------------------------------------
package uart_report_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    EMIT_DIG,
    EMIT_SEP,
    EMIT_TERM
  } state_t;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;

  // 10^n as a 64-bit value; only ever evaluated at elaboration time
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_report_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_report_sequencer_if
// Byte stream from the report sequencer to the UART transmitter.
//   tx_data  : byte being offered
//   tx_valid : tx_data is valid, held with tx_data until accepted
//   tx_ready : transmitter accepts the byte this cycle
// Modports: master (sequencer side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface uart_report_sequencer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_report_sequencer_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// Only the low DIGITS decimal digits are kept; higher digits fall off the top,
// which leaves the kept digits equal to the value modulo 10^DIGITS (callers
// that care about overflow check the binary value separately).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   i_load   : capture i_bin and start a conversion (WIDTH cycles)
//   i_bin    : binary value to convert
//   o_done   : high when no conversion is running and o_bcd is final
//   o_bcd    : DIGITS packed BCD digits, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    r_bin;
  logic [DIGITS*4-1:0] r_bcd;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS*4-1:0] w_adj;

  // Add 3 to every digit that is 5 or more so the following shift carries
  // correctly into the next decimal digit
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  // Load restarts a conversion; afterwards the binary register is shifted
  // into the BCD register one bit per cycle until the counter reaches zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      {r_bcd, r_bin} <= {w_adj[DIGITS*4-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/uart_report_sequencer.sv
// -----------------------------------------------------------------------------
// uart_report_sequencer
// Samples NUM_CH channel values on a trigger (manual start or PERIOD tick) and
// streams them as one ASCII line, e.g. "123,045,007\n", to a UART transmitter.
// Values above 10^DIGITS-1 print as all nines and pulse o_sat.
// Build macro: REPORT_ZERO_SUPPRESS_EN - leading zeros print as spaces
// (the last digit is always numeric); field width is unchanged.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_ch_data     : NUM_CH packed channel values, ch0 in [WIDTH-1:0]
//   i_start       : one-cycle manual report trigger
//   i_period_en   : enables the automatic PERIOD trigger
//   tx_if         : byte stream to the transmitter (master modport)
//   o_busy        : frame in progress
//   o_sat         : one-cycle pulse, a channel value was clamped
//   o_missed      : one-cycle pulse, a trigger arrived while busy
// -----------------------------------------------------------------------------
module uart_report_sequencer
  import uart_report_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter int         DIGITS = 3,
  parameter int         NUM_CH = 1,
  parameter int         PERIOD = 6000000,
  parameter logic [7:0] SEP    = COMMA,
  parameter logic [7:0] TERM   = LF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*WIDTH-1:0]   i_ch_data,
  input  logic                      i_start,
  input  logic                      i_period_en,
  uart_report_sequencer_if.master   tx_if,
  output logic                      o_busy,
  output logic                      o_sat,
  output logic                      o_missed
);

  localparam int          PCW     = $clog2(PERIOD + 1);
  localparam int          DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [63:0] SAT_MAX = pow10(DIGITS) - 64'd1;

  state_t                r_state;
  logic [PCW-1:0]        r_period_cnt;
  logic [NUM_CH*WIDTH-1:0] r_snap;
  logic [CHW-1:0]        r_ch;
  logic [DW-1:0]         r_dig;
  logic [DIGITS*4-1:0]   r_digits;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_sat;
  logic                  r_missed;

  logic                  w_tick;
  logic                  w_trigger;
  logic                  w_xfer;
  logic                  w_load;
  logic [WIDTH-1:0]      w_load_bin;
  logic [WIDTH-1:0]      w_cur_val;
  logic                  w_sat;
  logic                  w_conv_done;
  logic [DIGITS*4-1:0]   w_conv_bcd;
  logic [DIGITS*4-1:0]   w_bcd_fin;
  int                    w_next_idx;
  logic [7:0]            w_first_char;
  logic [7:0]            w_next_char;

  // ASCII for digit idx of a BCD field; with zero suppression a digit is
  // blank when it and every digit above it are zero, except the last digit
  function automatic logic [7:0] digit_char(input logic [DIGITS*4-1:0] bcd,
                                            input int idx);
    logic [3:0] d;
`ifdef REPORT_ZERO_SUPPRESS_EN
    logic       nz;
    nz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= idx && bcd[k*4 +: 4] != 4'd0) nz = 1'b1;
    end
    d = bcd[idx*4 +: 4];
    if (!nz && idx != 0) return SPACE;
`else
    d = bcd[idx*4 +: 4];
`endif
    return ZERO + {4'd0, d};
  endfunction

  assign w_tick    = i_period_en && (r_period_cnt == PCW'(PERIOD - 1));
  assign w_trigger = i_start | w_tick;
  assign w_xfer    = r_tx_valid && tx_if.tx_ready;

  // A conversion starts either from IDLE (ch0 straight from the input, the
  // snapshot is captured on the same edge) or after a separator is accepted
  assign w_load = ((r_state == IDLE) && w_trigger) ||
                  ((r_state == EMIT_SEP) && w_xfer);

  always_comb begin
    w_load_bin = i_ch_data[WIDTH-1:0];
    w_cur_val  = r_snap[WIDTH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_state != IDLE && c == int'(r_ch) + 1) w_load_bin = r_snap[c*WIDTH +: WIDTH];
      if (c == int'(r_ch)) w_cur_val = r_snap[c*WIDTH +: WIDTH];
    end
  end

  // Saturation is judged on the binary value since the converter only keeps
  // DIGITS digits
  always_comb begin
    w_sat        = 64'(w_cur_val) > SAT_MAX;
    w_bcd_fin    = w_sat ? {DIGITS{4'd9}} : w_conv_bcd;
    w_next_idx   = (r_dig == '0) ? 0 : int'(r_dig) - 1;
    w_first_char = digit_char(w_bcd_fin, DIGITS - 1);
    w_next_char  = digit_char(r_digits, w_next_idx);
  end

  // Free-running period counter, parked at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_cnt <= '0;
    end else if (!i_period_en || w_tick) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PCW'(1);
    end
  end

  // Report FSM; all outputs are registered so tx_valid never follows
  // tx_ready combinationally and tx_data only changes on a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_snap     <= '0;
      r_ch       <= '0;
      r_dig      <= '0;
      r_digits   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_sat      <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_sat    <= 1'b0;
      r_missed <= w_trigger && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_snap  <= i_ch_data;
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          if (w_conv_done) begin
            r_digits   <= w_bcd_fin;
            r_sat      <= w_sat;
            r_dig      <= DW'(DIGITS - 1);
            r_tx_data  <= w_first_char;
            r_tx_valid <= 1'b1;
            r_state    <= EMIT_DIG;
          end
        end
        EMIT_DIG: begin
          if (w_xfer) begin
            if (r_dig != '0) begin
              r_dig     <= r_dig - DW'(1);
              r_tx_data <= w_next_char;
            end else if (int'(r_ch) < NUM_CH - 1) begin
              r_tx_data <= SEP;
              r_state   <= EMIT_SEP;
            end else begin
              r_tx_data <= TERM;
              r_state   <= EMIT_TERM;
            end
          end
        end
        EMIT_SEP: begin
          if (w_xfer) begin
            r_ch       <= r_ch + CHW'(1);
            r_tx_valid <= 1'b0;
            r_state    <= CONV;
          end
        end
        EMIT_TERM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_bin  (w_load_bin),
    .o_done (w_conv_done),
    .o_bcd  (w_conv_bcd)
  );

  assign tx_if.tx_data  = r_tx_data;
  assign tx_if.tx_valid = r_tx_valid;
  assign o_busy         = r_busy;
  assign o_sat          = r_sat;
  assign o_missed       = r_missed;

endmodule

// File: tb/tb_uart_report_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_report_sequencer
// Directed and randomized frames for a two-channel, three-digit configuration
// with a 50-cycle period. Expected lines come from a decimal formatting model.
// Honours REPORT_ZERO_SUPPRESS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_report_sequencer;

  localparam int W    = 12;
  localparam int DIG  = 3;
  localparam int NCH  = 2;
  localparam int PER  = 50;
  localparam int MAXV = 999;
  localparam int MAXC = 1000;

  logic             clk;
  logic             rst;
  logic [NCH*W-1:0] chData;
  logic             start;
  logic             periodEn;
  logic             busy;
  logic             sat;
  logic             missed;

  uart_report_sequencer_if txIf ();

  uart_report_sequencer #(
    .WIDTH  (W),
    .DIGITS (DIG),
    .NUM_CH (NCH),
    .PERIOD (PER),
    .SEP    (8'h2C),
    .TERM   (8'h0A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ch_data   (chData),
    .i_start     (start),
    .i_period_en (periodEn),
    .tx_if       (txIf),
    .o_busy      (busy),
    .o_sat       (sat),
    .o_missed    (missed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         errors = 0;
  int         chVal[NCH];
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];
  int         riseQ[$];
  int         satCount = 0;
  int         expSat = 0;
  int         missedCount = 0;
  int         cycleCount = 0;
  logic       prevBusy = 1'b0;

  // Passive monitor on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (txIf.tx_valid && txIf.tx_ready && !rst) rxQ.push_back(txIf.tx_data);
    if (sat) satCount++;
    if (missed) missedCount++;
    if (busy && !prevBusy) riseQ.push_back(cycleCount);
    prevBusy = busy;
    cycleCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Expected line: each value clamped to 999, printed as DIG decimal digits
  task automatic modelFrame();
    for (int c = 0; c < NCH; c++) begin
      int v;
      bit leading;
      v = chVal[c];
      if (v > MAXV) begin
        v = MAXV;
        expSat++;
      end
      leading = 1'b1;
      for (int i = DIG - 1; i >= 0; i--) begin
        int d;
        d = (v / p10(i)) % 10;
`ifdef REPORT_ZERO_SUPPRESS_EN
        if (leading && d == 0 && i != 0) begin
          expQ.push_back(8'h20);
        end else begin
          leading = 1'b0;
          expQ.push_back(8'(8'h30 + d));
        end
`else
        leading = 1'b0;
        expQ.push_back(8'(8'h30 + d));
`endif
      end
      if (c < NCH - 1) expQ.push_back(8'h2C);
    end
    expQ.push_back(8'h0A);
  endtask

  task automatic setChannels(input int v0, input int v1);
    chVal[0] = v0;
    chVal[1] = v1;
    chData   = {v1[W-1:0], v0[W-1:0]};
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Load channels, trigger one frame and extend the expected stream
  task automatic applyStimulus(input int v0, input int v1);
    setChannels(v0, v1);
    pulseStart();
    modelFrame();
  endtask

  task automatic waitIdle(input bit randomReady, input string tag);
    int k = 0;
    while (busy && k < MAXC) begin
      @(posedge clk); #1;
      if (randomReady) txIf.tx_ready = 1'($urandom_range(0, 1));
      k++;
    end
    txIf.tx_ready = 1'b1;
    checkOutput({tag, " frame completes"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic checkFrames(input string tag);
    int n;
    checkOutput({tag, " byte count"}, rxQ.size(), expQ.size());
    n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s byte %0d", tag, i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
    end
    checkOutput({tag, " sat pulses"}, satCount, expSat);
    rxQ.delete();
    expQ.delete();
    satCount = 0;
    expSat   = 0;
  endtask

  initial begin
    int k;
    int c0;
    rst           = 1'b1;
    start         = 1'b0;
    periodEn      = 1'b0;
    chData        = '0;
    txIf.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset tx_valid", {31'd0, txIf.tx_valid}, 32'd0);
    checkOutput("reset tx_data", {24'd0, txIf.tx_data}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset sat", {31'd0, sat}, 32'd0);
    checkOutput("reset missed", {31'd0, missed}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    rxQ.delete();
    satCount = 0;
    missedCount = 0;

    $display("[TB] directed frame 123,7");
    applyStimulus(123, 7);
    k = 0;
    while (!txIf.tx_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("first byte latency", k, W + 1);
    waitIdle(1'b0, "directed");
    checkFrames("directed");

    $display("[TB] backpressure on second digit");
    applyStimulus($urandom_range(100, 999), $urandom_range(0, 999));
    k = 0;
    while (!txIf.tx_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("bp first byte", {24'd0, txIf.tx_data}, {24'd0, expQ[0]});
    @(posedge clk); #1 txIf.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp hold tx_data", {24'd0, txIf.tx_data}, {24'd0, expQ[1]});
      checkOutput("bp hold tx_valid", {31'd0, txIf.tx_valid}, 32'd1);
      @(posedge clk); #1;
    end
    txIf.tx_ready = 1'b1;
    waitIdle(1'b0, "backpressure");
    checkFrames("backpressure");

    $display("[TB] saturation and zero fields");
    applyStimulus(1000, 999);
    waitIdle(1'b0, "sat 1000");
    checkFrames("sat 1000");
    applyStimulus(999, 5);
    waitIdle(1'b0, "sat 999");
    checkFrames("sat 999");
    applyStimulus(5, 0);
    waitIdle(1'b0, "small values");
    checkFrames("small values");

    $display("[TB] randomized frames with random ready");
    for (int f = 0; f < 6; f++) begin
      applyStimulus($urandom_range(0, 1200), $urandom_range(0, 1200));
      waitIdle(1'b1, $sformatf("random %0d", f));
      checkFrames($sformatf("random %0d", f));
    end

    $display("[TB] overrun during conversion");
    missedCount = 0;
    applyStimulus($urandom_range(0, 999), $urandom_range(0, 999));
    repeat (3) @(posedge clk);
    pulseStart();
    waitIdle(1'b0, "overrun conv");
    repeat (5) @(posedge clk);
    checkFrames("overrun conv");
    checkOutput("overrun conv missed", missedCount, 1);

    $display("[TB] trigger on final terminator transfer");
    missedCount = 0;
    applyStimulus($urandom_range(0, 999), $urandom_range(0, 999));
    k = 0;
    while (!(txIf.tx_valid && txIf.tx_data == 8'h0A) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("term trigger busy", {31'd0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("term trigger stays idle", {31'd0, busy}, 32'd0);
    checkOutput("term trigger missed", missedCount, 1);
    checkFrames("term trigger");

    $display("[TB] periodic trigger");
    missedCount = 0;
    riseQ.delete();
    setChannels($urandom_range(0, 999), $urandom_range(0, 999));
    @(posedge clk); #1;
    periodEn = 1'b1;
    c0 = cycleCount;
    k = 0;
    while (riseQ.size() < 3 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    periodEn = 1'b0;
    repeat (3) modelFrame();
    waitIdle(1'b0, "period");
    checkOutput("period frame count", riseQ.size(), 3);
    if (riseQ.size() >= 3) begin
      checkOutput("period first start", riseQ[0] - c0, PER);
      checkOutput("period interval 1", riseQ[1] - riseQ[0], PER);
      checkOutput("period interval 2", riseQ[2] - riseQ[1], PER);
    end
    checkFrames("period");
    repeat (150) @(posedge clk);
    #1;
    checkOutput("period disabled no frames", riseQ.size(), 3);
    checkOutput("period missed", missedCount, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(456, 78);
    k = 0;
    while (rxQ.size() < 3 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    rst = 1'b1;
    #1;
    checkOutput("mid reset tx_valid", {31'd0, txIf.tx_valid}, 32'd0);
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid reset byte count", rxQ.size(), 3);
    for (int i = 0; i < 3 && i < rxQ.size(); i++) begin
      checkOutput($sformatf("mid reset byte %0d", i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
    end
    rxQ.delete();
    expQ.delete();
    expSat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post reset idle valid", {31'd0, txIf.tx_valid}, 32'd0);
    satCount = 0;
    applyStimulus(321, 654);
    waitIdle(1'b0, "post reset");
    checkFrames("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
